// File: rtl/alu_seq.sv
// Registered one-hot-select ALU with a start/busy/done handshake. Shifts run one bit
// per cycle. Defining ALU_MUL_EN builds the iterative shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s_sub,
  input  logic             s_fas,
  input  logic             s_and,
  input  logic             s_or,
  input  logic             s_xor,
  input  logic             s_not,
  input  logic             s_shl,
  input  logic             s_shr,
  input  logic             s_mul,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             zf,
  output logic             nf,
  output logic             vf,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;  // must hold WIDTH for the multiply count

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR, OP_MUL
  } op_t;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_r;
  op_t              op_s;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             shl_r;
  logic             last_r;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] res_s;
  logic             cout_s;
  logic             vf_s;

  // Priority decode of the one-hot selects; s_sub alone is a no-op
  always_comb begin
    op_s = OP_NOP;
    if (s_mul) begin
`ifdef ALU_MUL_EN
      op_s = OP_MUL;
`else
      op_s = OP_NOP;
`endif
    end else if (s_shl) begin
      op_s = OP_SHL;
    end else if (s_shr) begin
      op_s = OP_SHR;
    end else if (s_fas) begin
      op_s = s_sub ? OP_SUB : OP_ADD;
    end else if (s_and) begin
      op_s = OP_AND;
    end else if (s_or) begin
      op_s = OP_OR;
    end else if (s_xor) begin
      op_s = OP_XOR;
    end else if (s_not) begin
      op_s = OP_NOT;
    end else begin
      op_s = OP_NOP;
    end
  end

  assign b_eff_s = (op_s == OP_SUB) ? ~b : b;
  assign sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, (op_s == OP_SUB)};

  // Result and flags of the single-cycle operations
  always_comb begin
    res_s  = {WIDTH{1'b0}};
    cout_s = 1'b0;
    vf_s   = 1'b0;
    case (op_s)
      OP_ADD, OP_SUB: begin
        res_s  = sum_s[WIDTH-1:0];
        cout_s = sum_s[WIDTH];
        vf_s   = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_s = a & b;
      OP_OR:   res_s = a | b;
      OP_XOR:  res_s = a ^ b;
      OP_NOT:  res_s = ~a;
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [WIDTH:0]     madd_s;

  // Conditional add of the multiplicand into the upper half of the product
  always_comb begin
    madd_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]}
           + (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
  end
`endif

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      r       <= {WIDTH{1'b0}};
      cout    <= 1'b0;
      zf      <= 1'b0;
      nf      <= 1'b0;
      vf      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      shl_r   <= 1'b0;
      last_r  <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_r <= {WIDTH{1'b0}};
      prod_r  <= {(2*WIDTH){1'b0}};
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            case (op_s)
              OP_SHL, OP_SHR: begin
                acc_r   <= a;
                cnt_r   <= {1'b0, b[SHW-1:0]};
                shl_r   <= (op_s == OP_SHL);
                last_r  <= 1'b0;
                busy    <= 1'b1;
                state_r <= SHIFT;
              end
`ifdef ALU_MUL_EN
              OP_MUL: begin
                mcand_r <= a;
                prod_r  <= {{WIDTH{1'b0}}, b};
                cnt_r   <= CW'(WIDTH);
                busy    <= 1'b1;
                state_r <= MUL;
              end
`endif
              default: begin
                r    <= res_s;
                cout <= cout_s;
                vf   <= vf_s;
                zf   <= (res_s == {WIDTH{1'b0}});
                nf   <= res_s[WIDTH-1];
                done <= 1'b1;
              end
            endcase
          end
        end
        SHIFT: begin
          if (cnt_r != {CW{1'b0}}) begin
            if (shl_r) begin
              last_r <= acc_r[WIDTH-1];
              acc_r  <= {acc_r[WIDTH-2:0], 1'b0};
            end else begin
              last_r <= acc_r[0];
              acc_r  <= {1'b0, acc_r[WIDTH-1:1]};
            end
            cnt_r <= cnt_r - CW'(1);
          end else begin
            r       <= acc_r;
            cout    <= last_r;
            vf      <= 1'b0;
            zf      <= (acc_r == {WIDTH{1'b0}});
            nf      <= acc_r[WIDTH-1];
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          if (cnt_r != {CW{1'b0}}) begin
            prod_r <= {madd_s, prod_r[WIDTH-1:1]};
            cnt_r  <= cnt_r - CW'(1);
          end else begin
            r       <= prod_r[WIDTH-1:0];
            cout    <= |prod_r[2*WIDTH-1:WIDTH];
            vf      <= 1'b0;
            zf      <= (prod_r[WIDTH-1:0] == {WIDTH{1'b0}});
            nf      <= prod_r[WIDTH-1];
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
`endif
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=16; multiply vectors follow ALU_MUL_EN.
module tb_alu_seq;

  localparam logic [8:0] SEL_NOT = 9'h001, SEL_XOR = 9'h002, SEL_OR  = 9'h004,
                         SEL_AND = 9'h008, SEL_SUB = 9'h010, SEL_FAS = 9'h020,
                         SEL_SHR = 9'h040, SEL_SHL = 9'h080, SEL_MUL = 9'h100;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [8:0]  sel;
    logic [15:0] er;
    logic        ec, ez, en, ev;
    int          lat;
  } vec_t;

  logic        clk_s = 1'b0, rst_s, start_s;
  logic [15:0] a_s, b_s, r_s;
  logic [8:0]  sel_s;
  logic        cout_s, zf_s, nf_s, vf_s, busy_s, done_s;
  int          n_cmp = 0, n_fail = 0;
  vec_t        vecs[$];

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk_s), .rst(rst_s), .start(start_s), .a(a_s), .b(b_s),
    .s_sub(sel_s[4]), .s_fas(sel_s[5]), .s_and(sel_s[3]), .s_or(sel_s[2]),
    .s_xor(sel_s[1]), .s_not(sel_s[0]), .s_shl(sel_s[7]), .s_shr(sel_s[6]),
    .s_mul(sel_s[8]), .r(r_s), .cout(cout_s), .zf(zf_s), .nf(nf_s), .vf(vf_s),
    .busy(busy_s), .done(done_s)
  );

  always #5 clk_s = ~clk_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Issue one operation, scramble the inputs, then wait (bounded) for done
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic [8:0] sel,
                        output int lat, output int bcnt);
    a_s = ta; b_s = tb; sel_s = sel; start_s = 1'b1;
    @(negedge clk_s);
    start_s = 1'b0; a_s = ~ta; b_s = ~tb; sel_s = 9'h000;
    lat = 1; bcnt = 0;
    while (!done_s && lat < 100) begin
      if (busy_s) bcnt++;
      @(negedge clk_s);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, ndone;
    rst_s = 1'b1; start_s = 1'b0; a_s = 16'h0000; b_s = 16'h0000; sel_s = 9'h000;

    vecs.push_back('{16'hFFFF, 16'h0001, SEL_FAS,           16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{16'h8000, 16'h0001, SEL_FAS | SEL_SUB, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{16'h1234, 16'h4321, SEL_FAS | SEL_AND, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{16'h7FFF, 16'h0001, SEL_FAS,           16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{16'h0005, 16'h0007, SEL_FAS | SEL_SUB, 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{16'hF0F0, 16'h3C3C, SEL_AND | SEL_OR,  16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{16'hF0F0, 16'h0F00, SEL_OR,            16'hFFF0, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{16'h0F0F, 16'h00FF, SEL_XOR | SEL_NOT, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{16'h00FF, 16'h1234, SEL_NOT,           16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{16'h1234, 16'h5678, SEL_SUB,           16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{16'h1801, 16'h0004, SEL_SHL | SEL_FAS, 16'h8010, 1'b1, 1'b0, 1'b1, 1'b0, 6});
    vecs.push_back('{16'h1234, 16'h0000, SEL_SHL,           16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 2});
    vecs.push_back('{16'h8001, 16'h0011, SEL_SHR,           16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 3});
`ifdef ALU_MUL_EN
    vecs.push_back('{16'h00FF, 16'h0003, SEL_MUL,           16'h02FD, 1'b0, 1'b0, 1'b0, 1'b0, 18});
    vecs.push_back('{16'h0100, 16'h0100, SEL_MUL | SEL_SHL, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 18});
`else
    vecs.push_back('{16'h0003, 16'h0004, SEL_MUL | SEL_FAS, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1});
`endif

    repeat (2) @(negedge clk_s);
    rst_s = 1'b0;
    chk("reset r", r_s, 16'h0000);
    chk("reset flags", {cout_s, zf_s, nf_s, vf_s, busy_s, done_s}, 6'b000000);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sel, lat, bcnt);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d busy cycles", i), bcnt, vecs[i].lat - 1);
      chk($sformatf("v%0d r", i), r_s, vecs[i].er);
      chk($sformatf("v%0d cout/zf/nf/vf", i), {cout_s, zf_s, nf_s, vf_s},
          {vecs[i].ec, vecs[i].ez, vecs[i].en, vecs[i].ev});
      @(negedge clk_s);
      chk($sformatf("v%0d done pulse/hold", i), {done_s, busy_s, r_s}, {2'b00, vecs[i].er});
    end

    // Long shift right; a start during busy must be ignored
    a_s = 16'h8000; b_s = 16'h000F; sel_s = SEL_SHR; start_s = 1'b1;
    @(negedge clk_s);
    start_s = 1'b0; sel_s = 9'h000;
    lat = 1; ndone = 0;
    while (!done_s && lat < 100) begin
      if (lat == 3) begin
        a_s = 16'h0001; b_s = 16'h0001; sel_s = SEL_FAS; start_s = 1'b1;
      end
      @(negedge clk_s);
      start_s = 1'b0; sel_s = 9'h000;
      lat++;
      if (done_s) ndone++;
    end
    chk("shr latency", lat, 17);
    chk("shr r", r_s, 16'h0001);
    chk("shr cout/zf/nf/vf", {cout_s, zf_s, nf_s, vf_s}, 4'b0000);
    // Back-to-back add issued in the done cycle
    a_s = 16'h0010; b_s = 16'h0020; sel_s = SEL_FAS; start_s = 1'b1;
    @(negedge clk_s);
    start_s = 1'b0; sel_s = 9'h000;
    chk("shr single done", ndone, 1);
    chk("b2b add r", r_s, 16'h0030);
    chk("b2b add done/busy", {done_s, busy_s}, 2'b10);

    // Reset in the middle of a multi-cycle operation
`ifdef ALU_MUL_EN
    a_s = 16'h00FF; b_s = 16'h0003; sel_s = SEL_MUL; start_s = 1'b1;
`else
    a_s = 16'h8000; b_s = 16'h000F; sel_s = SEL_SHR; start_s = 1'b1;
`endif
    @(negedge clk_s);
    start_s = 1'b0; sel_s = 9'h000;
    repeat (4) @(negedge clk_s);
    chk("mid-op busy", busy_s, 1'b1);
    rst_s = 1'b1;
    @(negedge clk_s);
    rst_s = 1'b0;
    chk("mid-op reset r", r_s, 16'h0000);
    chk("mid-op reset flags", {cout_s, zf_s, nf_s, vf_s, busy_s, done_s}, 6'b000000);
    ndone = 0;
    repeat (20) begin
      @(negedge clk_s);
      if (done_s) ndone++;
    end
    chk("no done after reset", ndone, 0);
    run_op(16'h0002, 16'h0003, SEL_FAS, lat, bcnt);
    chk("post-reset add latency", lat, 1);
    chk("post-reset add r", r_s, 16'h0005);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
